psoc_audio_tdm_tx: RTL and testbench

Parametrised next-generation audio serializer for the PSoC audio IP. It replaces the fixed 2-channel I2S output path. It takes whole multi-channel frames from a FIFO-style valid/ready source and serializes them in I2S, left-justified or TDM format. The divided MCLK/SCLK are generated internally. It adds graceful stop, per-frame mute, and underrun detection with a saturating counter, which the register file reads.

---
 rtl/psoc_audio_tdm_tx.sv | 181 ++++++++++++++++++
 tb/tb_psoc_audio_tdm_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psoc_audio_tdm_tx.sv
// Multi-channel audio serializer: pops whole frames from a valid/ready source and
// shifts them out as I2S, left-justified or TDM with internally divided MCLK/SCLK.
module psoc_audio_tdm_tx #(
  parameter int SAMPLE_BITS       = 24,
  parameter int SLOT_BITS         = 32,
  parameter int CHANNELS          = 2,
  parameter int MCLK_DIV          = 4,
  parameter int SCLK_DIV          = 16,
  parameter int UNDERRUN_CNT_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [1:0]                        mode,
  input  logic                              mute,
  input  logic [CHANNELS*SAMPLE_BITS-1:0]   frame_data,
  input  logic                              frame_valid,
  output logic                              frame_ready,
  input  logic                              clear_underrun,
  output logic                              underrun,
  output logic [UNDERRUN_CNT_BITS-1:0]      underrun_count,
  output logic                              busy,
  output logic                              mclk,
  output logic                              sclk,
  output logic                              lrclk,
  output logic                              sdata
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int DATA_BITS  = CHANNELS * SAMPLE_BITS;
  localparam int MCLK_W     = $clog2(MCLK_DIV);
  localparam int DIV_W      = $clog2(SCLK_DIV);
  localparam int BIT_W      = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;

  localparam logic [MCLK_W-1:0] MCLK_LAST = MCLK_W'(MCLK_DIV - 1);
  localparam logic [MCLK_W-1:0] MCLK_HALF = MCLK_W'(MCLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_HALF  = BIT_W'(FRAME_BITS / 2);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  typedef enum logic [1:0] {FMT_I2S, FMT_LJ, FMT_TDM} fmt_e;

  state_e                       state_q, state_d;
  fmt_e                         fmt_q, fmt_d;
  logic [MCLK_W-1:0]            mclk_cnt_q, mclk_cnt_d;
  logic [DIV_W-1:0]             div_q, div_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [FRAME_BITS-1:0]        ser_q, ser_d, load_vec;
  logic [UNDERRUN_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                         mclk_q, mclk_d, sclk_q, sclk_d;
  logic                         lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic [DATA_BITS-1:0]         load_src;
  logic                         load, load_miss;

  assign load_src = (frame_valid && !mute) ? frame_data : '0;

  // Reorder the captured samples into transmit order: frame bit b sits at ser[b], MSB first per slot.
  always_comb begin
    load_vec = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      for (int j = 0; j < SAMPLE_BITS; j++) begin
        load_vec[s*SLOT_BITS + j] = load_src[s*SAMPLE_BITS + SAMPLE_BITS - 1 - j];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    fmt_d      = fmt_q;
    div_d      = '0;
    bit_d      = '0;
    ser_d      = ser_q;
    sdata_d    = sdata_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    mclk_cnt_d = (mclk_cnt_q == MCLK_LAST) ? '0 : mclk_cnt_q + 1'b1;
    mclk_d     = (mclk_cnt_d >= MCLK_HALF);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          load    = 1'b1;
          state_d = RUN;
          unique case (mode)
            2'd1:    fmt_d = FMT_LJ;
            2'd2:    fmt_d = FMT_TDM;
            default: fmt_d = FMT_I2S;
          endcase
        end
      end
      default: begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        state_d = enable ? RUN : STOP;
        if (div_q == DIV_LAST) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            load    = enable;
            state_d = enable ? RUN : IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
    endcase

    load_miss = load && !frame_valid;

    // ser[0] always holds the data bit of the current SCLK period; I2S sends it one period late.
    if (load) begin
      ser_d   = load_vec;
      sdata_d = (fmt_d == FMT_I2S) ? ser_q[0] : load_vec[0];
    end else if (state_d == IDLE) begin
      ser_d   = '0;
      sdata_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      ser_d   = ser_q >> 1;
      sdata_d = (fmt_q == FMT_I2S) ? ser_q[0] : ser_q[1];
    end

    sclk_d  = (state_d != IDLE) && (div_d >= DIV_HALF);
    lrclk_d = 1'b0;
    if (state_d != IDLE) begin
      unique case (fmt_d)
        FMT_LJ:  lrclk_d = (bit_d < BIT_HALF);
        FMT_TDM: lrclk_d = (bit_d == '0);
        default: lrclk_d = (bit_d >= BIT_HALF);
      endcase
    end

    if (clear_underrun) begin
      cnt_d = '0;
    end else if (load_miss && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide shift register is reset too, so the I2S lead-in bit after reset is a defined 0.
      state_q    <= IDLE;
      fmt_q      <= FMT_I2S;
      mclk_cnt_q <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      ser_q      <= '0;
      cnt_q      <= '0;
      mclk_q     <= 1'b0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fmt_q      <= fmt_d;
      mclk_cnt_q <= mclk_cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      ser_q      <= ser_d;
      cnt_q      <= cnt_d;
      mclk_q     <= mclk_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
    end
  end

  // The pop strobe must coincide with the capture, so it is decoded rather than registered.
  assign frame_ready    = load && !rst;
  assign underrun       = load_miss && !rst;
  assign underrun_count = cnt_q;
  assign busy           = (state_q != IDLE);
  assign mclk           = mclk_q;
  assign sclk           = sclk_q;
  assign lrclk          = lrclk_q;
  assign sdata          = sdata_q;

endmodule

// File: tb/tb_psoc_audio_tdm_tx.sv
// Randomized bench for psoc_audio_tdm_tx: every cycle is compared against a frame-level
// model that derives pin values from the time elapsed since the last frame load.
module tb_psoc_audio_tdm_tx;

  localparam int CH  = 4;
  localparam int SB  = 24;
  localparam int SL  = 32;
  localparam int MD  = 4;
  localparam int SD  = 16;
  localparam int UCB = 2;
  localparam int FB  = CH * SL;
  localparam int FC  = FB * SD;
  localparam int CNT_MAX = (1 << UCB) - 1;

  logic              clk = 1'b0;
  logic              rst, enable, mute, frame_valid, clear_underrun;
  logic [1:0]        mode;
  logic [CH*SB-1:0]  frame_data;
  logic              frame_ready, underrun, busy, mclk, sclk, lrclk, sdata;
  logic [UCB-1:0]    underrun_count;

  psoc_audio_tdm_tx #(
    .SAMPLE_BITS(SB), .SLOT_BITS(SL), .CHANNELS(CH),
    .MCLK_DIV(MD), .SCLK_DIV(SD), .UNDERRUN_CNT_BITS(UCB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .mute(mute),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .clear_underrun(clear_underrun), .underrun(underrun), .underrun_count(underrun_count),
    .busy(busy), .mclk(mclk), .sclk(sclk), .lrclk(lrclk), .sdata(sdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ready = 0;
  int n_ones = 0;
  bit rand_data = 1'b1;

  // Reference model: streaming flag, cycles since load, transmit-order bits of the frame.
  bit m_active = 1'b0;
  int m_t = 0;
  bit m_bits [FB];
  bit m_prev = 1'b0;
  int m_mode = 0;
  int m_cnt = 0;
  int m_clk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [CH*SB-1:0] rand_frame();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [3:0] exp_pins();
    int b;
    logic sc, lr, sd;
    if (!m_active) return 4'b0;
    b  = m_t / SD;
    sc = (m_t % SD) >= SD / 2;
    if (m_mode == 1) begin
      sd = m_bits[b];
      lr = (b < FB / 2);
    end else if (m_mode == 2) begin
      sd = m_bits[b];
      lr = (b == 0);
    end else begin
      if (b == 0) sd = m_prev;
      else        sd = m_bits[b-1];
      lr = (b >= FB / 2);
    end
    return {1'b1, sc, lr, sd};
  endfunction

  task automatic model_edge(input logic r, input logic ld, input logic [1:0] md,
                            input logic vld, input logic mu, input logic clr,
                            input logic [CH*SB-1:0] data);
    if (r) begin
      m_active = 1'b0; m_t = 0; m_cnt = 0; m_clk = 0; m_prev = 1'b0;
      return;
    end
    m_clk++;
    if (ld) begin
      if (!m_active) begin
        m_mode = (md == 2'd3) ? 0 : int'(md);
        m_prev = 1'b0;
      end else begin
        m_prev = m_bits[FB-1];
      end
      for (int s = 0; s < CH; s++) begin
        for (int j = 0; j < SL; j++) begin
          if (j < SB && vld && !mu) m_bits[s*SL + j] = data[s*SB + SB - 1 - j];
          else                      m_bits[s*SL + j] = 1'b0;
        end
      end
      m_active = 1'b1;
      m_t = 0;
    end else if (m_active) begin
      if (m_t == FC - 1) m_active = 1'b0;
      else               m_t++;
    end
    if (clr) m_cnt = 0;
    else if (ld && !vld && m_cnt < CNT_MAX) m_cnt++;
  endtask

  // One clock: check decoded strobes before the edge, registered pins after it.
  task automatic cyc();
    logic ld, r_s, v_s, mu_s, c_s;
    logic [1:0] md_s;
    logic [CH*SB-1:0] d_s;
    #1;
    ld = !rst && enable && (!m_active || m_t == FC - 1);
    check("frame_ready", frame_ready, ld);
    check("underrun", underrun, ld && !frame_valid);
    if (frame_ready) n_ready++;
    r_s = rst; v_s = frame_valid; mu_s = mute; c_s = clear_underrun; md_s = mode; d_s = frame_data;
    @(posedge clk);
    model_edge(r_s, ld, md_s, v_s, mu_s, c_s, d_s);
    #1;
    check("pins", {busy, sclk, lrclk, sdata}, exp_pins());
    check("mclk", mclk, (m_clk % MD) >= MD / 2);
    check("underrun_count", underrun_count, m_cnt);
    if (sdata) n_ones++;
    @(negedge clk);
    if (rand_data) frame_data = rand_frame();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until the next cycle is the last cycle of the current frame.
  task automatic run_to_eof();
    for (int i = 0; i < FC + 8; i++) begin
      if (m_active && m_t == FC - 1) break;
      cyc();
    end
  endtask

  task automatic finish_idle();
    enable = 1'b0;
    run_to_eof();
    run(4);
  endtask

  initial begin
    int r0, o0;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; mute = 1'b0; frame_valid = 1'b1;
    clear_underrun = 1'b0; frame_data = rand_frame();
    run(3);
    rst = 1'b0;
    check("reset_outs", {frame_ready, underrun, busy, sclk, lrclk, sdata, mclk}, 7'b0);
    run(5);

    // Left-justified: two frames, enable dropped at bit 10 of the second.
    mode = 2'd1; enable = 1'b1; r0 = n_ready;
    cyc();
    run(FC + 10 * SD);
    enable = 1'b0;
    run_to_eof();
    run(4);
    check("lj_loads", n_ready - r0, 2);
    check("lj_idle_busy", busy, 1'b0);

    // I2S via mode=3; a mode change while streaming must not take effect.
    mode = 2'd3; enable = 1'b1;
    cyc();
    mode = 2'd1;
    run(FC + $urandom_range(1, FC - 2));
    finish_idle();

    // TDM with only slot 3 loaded with ones, then a random frame.
    mode = 2'd2; enable = 1'b1; rand_data = 1'b0;
    frame_data = '0;
    frame_data[3*SB +: SB] = {SB{1'b1}};
    o0 = n_ones;
    cyc();
    rand_data = 1'b1;
    run(FC - 1);
    check("tdm_ones", n_ones - o0, SB * SD);
    run($urandom_range(1, FC - 2));
    finish_idle();

    // Underruns: saturate the 2-bit counter, then clear on an underrun load.
    mode = 2'd1; frame_valid = 1'b0; enable = 1'b1;
    cyc();
    run(4 * FC);
    check("sat_count", underrun_count, CNT_MAX);
    run_to_eof();
    clear_underrun = 1'b1;
    cyc();
    clear_underrun = 1'b0;
    check("clr_count", underrun_count, 0);
    frame_valid = 1'b1;
    finish_idle();

    // Mute: valid data is popped but transmitted as zeros.
    mode = 2'd0; mute = 1'b1; enable = 1'b1; o0 = n_ones; r0 = n_ready;
    cyc();
    mute = 1'b0; enable = 1'b0;
    run(FC - 1);
    check("mute_pop", n_ready - r0, 1);
    check("mute_ones", n_ones - o0, 0);
    run(4);

    // STOP then re-enable: the next frame must follow with no gap.
    mode = 2'd1; enable = 1'b1;
    cyc();
    run(200);
    enable = 1'b0;
    run(300);
    check("stop_busy", busy, 1'b1);
    enable = 1'b1;
    run_to_eof();
    r0 = n_ready;
    cyc();
    check("restart_load", n_ready - r0, 1);
    check("restart_busy", busy, 1'b1);
    run(50);

    // Synchronous reset mid-frame at bit 20.
    run_to_eof();
    cyc();
    run(20 * SD + 5);
    rst = 1'b1;
    cyc();
    check("rst_mid", {busy, sclk, lrclk, sdata}, 4'b0);
    rst = 1'b0; enable = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: bench did not complete within the cycle budget");
    $fatal(1);
  end

endmodule
